user_io_fifo: RTL and testbench
===============================

Name: user_io_fifo

Overview:
- Parametrised successor to the MiST user_io SPI slave. Receives IO-controller commands over SPI, oversampled entirely in clk_sys; no SPI_CLK clock domain.
- Decodes buttons/switches, N joysticks of configurable width, and a multi-byte status word.
- Keyboard/mouse traffic is queued in an event FIFO with ready/valid handshake and overflow flag, so slow consumers (CIA keyboard, mouse counters) lose nothing.

Parameters:
- NUM_JOY, 4: joysticks decoded (1..8); command 0x60+i for i < NUM_JOY.
- JOY_BYTES, 2: bytes stored per joystick (1..4).
- STATUS_BYTES, 4: status word length in bytes (1..8).
- FIFO_DEPTH, 16: event FIFO entries; power of 2, 4..64.

Ports:
- clk_sys  in  1  system clock; must be ≥ 4× SPI_CLK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- SPI_CLK  in  1  SPI clock, asynchronous, sampled.
- SPI_SS_IO  in  1  chip select, active low, sampled.
- SPI_MOSI  in  1  data from IO controller.
- SPI_MISO  out  1  data to IO controller; Z while deselected.
- CORE_TYPE  in  8  returned on byte 0.
- BUTTONS  out  2  but_sw[1:0].
- SWITCHES  out  2  but_sw[3:2].
- CONF  out  4  but_sw[7:4].
- JOY  out  NUM_JOY*8*JOY_BYTES  packed joysticks; joystick i occupies slice i.
- STATUS  out  8*STATUS_BYTES  status word.
- EVT_VALID  out  1  FIFO head valid.
- EVT_READY  in  1  consumer pops head when EVT_VALID & EVT_READY.
- EVT_TYPE  out  2  0 = mouse x, 1 = mouse y, 2 = key, 3 = OSD key (wheel uses 0 with EVT_WHEEL).
- EVT_WHEEL  out  1  head is a wheel delta.
- EVT_IDX  out  1  mouse index.
- EVT_DATA  out  8  payload.
- MOUSE0_BUTTONS  out  3  mouse 0 buttons.
- MOUSE1_BUTTONS  out  3  mouse 1 buttons.
- EVT_OVERFLOW  out  1  sticky drop flag.
- EVT_OVF_CLR  in  1  clears EVT_OVERFLOW.
- RTC  out  64  real-time clock.
- RTC_STROBE  out  1  one-cycle pulse on RTC update.

Behaviour:
- Reset: all outputs 0 except SPI_MISO = Z; FIFO empty; counters 0; armed = 0.
- Input sampling: SPI_CLK, SPI_SS_IO and SPI_MOSI pass through 2-flop synchronisers. Edges are detected on synced SPI_CLK; MOSI is sampled with the same delay.
- armed: set on the first cycle synced SS is high after reset. Edges are ignored while armed = 0, so a reset released mid-transfer discards the remainder of that transfer.
- SS high (synced): bit_cnt and byte_cnt are 0; SPI_MISO = Z.
- SS falling: SPI_MISO = CORE_TYPE[7].
- SCK rising: shift MOSI into the byte. On bit 7 the byte is complete and is processed the next cycle. byte_cnt saturates at 255.
- SCK falling: SPI_MISO = next CORE_TYPE bit, MSB first, during byte 0; 0 thereafter.
- Byte 0 is the command. Bytes k ≥ 1 are data:
  - 0x01: k = 1 → but_sw.
  - 0x60+i (i < NUM_JOY): 1 ≤ k ≤ JOY_BYTES → joystick i byte k-1, little-endian. Extra bytes ignored. Commands with i ≥ NUM_JOY are ignored.
  - 0x1E: 1 ≤ k ≤ STATUS_BYTES → STATUS byte k-1, little-endian.
  - 0x70/0x71: idx = cmd[0].
    - k = 1: push {type 0, idx, x}.
    - k = 2: push {type 1, idx, y}.
    - k = 3: buttons[2:0] → MOUSE{idx}_BUTTONS, no push.
    - k = 4: push {type 0, wheel 1, idx, data}.
    - k > 4: ignored.
  - 0x05: every data byte pushes type 2, idx 0.
  - 0x06: every data byte pushes type 3, idx 0.
  - Unknown commands: all bytes ignored.
- Output timing: register and push effects appear 1 clk_sys after the byte completes.
- FIFO: at most one push per cycle. Head is presented registered; EVT_* fields are stable while EVT_VALID & !EVT_READY.
  - Pop: EVT_VALID & EVT_READY.
  - Push when count < FIFO_DEPTH: accepted.
  - Push and pop in the same cycle when full: both accepted, count unchanged.
  - Push when full with no pop: dropped; EVT_OVERFLOW = 1 next cycle.
  - Push and pop in the same cycle when empty: entry stored; EVT_VALID = 1 next cycle. There is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- EVT_OVERFLOW: a set event and EVT_OVF_CLR in the same cycle → set wins.
- SS rising mid-byte: partial byte discarded; no effect.

Optional Feature:
- Macro USER_IO_RTC_EN.
- Defined: command 0x22 bytes k = 1..8 → RTC byte k-1, little-endian. RTC_STROBE pulses one cycle after byte 8 is applied.
- Undefined: RTC = 0, RTC_STROBE = 0, command 0x22 ignored like an unknown command.

Test Plan:
- Transfer 0x01,0xA5 at SCK = clk/8 → BUTTONS = 1, SWITCHES = 1, CONF = 0xA. MISO bits during byte 0 equal CORE_TYPE = 0xA5, MSB first.
- NUM_JOY = 4, JOY_BYTES = 2: send 0x62,0x34,0x12,0xFF → JOY slice 2 = 0x1234, other slices 0. Send 0x67,0x11 → no change.
- Send 0x71,0x05,0xFB,0x03,0x01 with EVT_READY = 1 → pops in order {0,0,1,0x05}, {1,0,1,0xFB}, {0,1,1,0x01}; MOUSE1_BUTTONS = 3.
- FIFO_DEPTH = 4, EVT_READY = 0: send 0x05 + 6 key bytes → 4 entries held, EVT_OVERFLOW = 1. Drain yields the first 4 bytes in order. Pulse EVT_OVF_CLR → 0.
- Deassert reset_n mid 0x1E transfer: STATUS = 0; later bytes of that transfer ignored. The next transfer 0x1E,0x78,0x56,0x34,0x12 → STATUS = 0x12345678.
- USER_IO_RTC_EN defined: 0x22 + 8 bytes 0x01..0x08 → RTC = 0x0807060504030201 and one RTC_STROBE pulse. Undefined: RTC stays 0.

Source files
------------

// File: rtl/user_io_fifo_if.sv
// Event stream between user_io_fifo (master) and a keyboard/mouse consumer (slave).
// The head entry is held stable while EVT_VALID is high and EVT_READY is low.
interface user_io_fifo_if;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [1:0] EVT_TYPE;
    logic       EVT_WHEEL;
    logic       EVT_IDX;
    logic [7:0] EVT_DATA;

    modport master (
        output EVT_VALID,
        output EVT_TYPE,
        output EVT_WHEEL,
        output EVT_IDX,
        output EVT_DATA,
        input  EVT_READY
    );

    modport slave (
        input  EVT_VALID,
        input  EVT_TYPE,
        input  EVT_WHEEL,
        input  EVT_IDX,
        input  EVT_DATA,
        output EVT_READY
    );
endinterface

// File: rtl/user_io_fifo.sv
// SPI command slave oversampled in clk_sys: buttons, joysticks, status and a keyboard/mouse event FIFO.
// Define USER_IO_RTC_EN to accept RTC command 0x22; otherwise RTC and RTC_STROBE are tied to 0.
module user_io_fifo #(
    parameter int unsigned NUM_JOY      = 4,
    parameter int unsigned JOY_BYTES    = 2,
    parameter int unsigned STATUS_BYTES = 4,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic                           SPI_CLK,
    input  logic                           SPI_SS_IO,
    input  logic                           SPI_MOSI,
    output logic                           SPI_MISO,
    input  logic [7:0]                     CORE_TYPE,
    output logic [1:0]                     BUTTONS,
    output logic [1:0]                     SWITCHES,
    output logic [3:0]                     CONF,
    output logic [NUM_JOY*8*JOY_BYTES-1:0] JOY,
    output logic [8*STATUS_BYTES-1:0]      STATUS,
    user_io_fifo_if.master                 evt,
    output logic [2:0]                     MOUSE0_BUTTONS,
    output logic [2:0]                     MOUSE1_BUTTONS,
    output logic                           EVT_OVERFLOW,
    input  logic                           EVT_OVF_CLR,
    output logic [63:0]                    RTC,
    output logic                           RTC_STROBE
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [1:0] typ;
        logic       wheel;
        logic       idx;
        logic [7:0] data;
    } evt_t;

    // SPI front end
    logic       sck_m, sck_s, sck_d;
    logic       ss_m, ss_s, ss_d;
    logic       mosi_m, mosi_s;
    logic       armed;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic       byte_done;
    logic [7:0] byte_val;
    logic [7:0] byte_idx;
    logic       miso_bit, miso_oe;
    logic       sck_rise, sck_fall;

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign SPI_MISO = miso_oe ? miso_bit : 1'bz;

    // Synchronisers reset low so a reset released while SS is low keeps armed clear until SS rises.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_m     <= 1'b0;
            sck_s     <= 1'b0;
            sck_d     <= 1'b0;
            ss_m      <= 1'b0;
            ss_s      <= 1'b0;
            ss_d      <= 1'b0;
            mosi_m    <= 1'b0;
            mosi_s    <= 1'b0;
            armed     <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_done <= 1'b0;
            byte_val  <= '0;
            byte_idx  <= '0;
            miso_bit  <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            sck_m     <= SPI_CLK;
            sck_s     <= sck_m;
            sck_d     <= sck_s;
            ss_m      <= SPI_SS_IO;
            ss_s      <= ss_m;
            ss_d      <= ss_s;
            mosi_m    <= SPI_MOSI;
            mosi_s    <= mosi_m;
            byte_done <= 1'b0;
            if (ss_s) begin
                armed    <= 1'b1;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                miso_oe  <= 1'b0;
            end else if (armed) begin
                if (ss_d) begin
                    miso_oe  <= 1'b1;
                    miso_bit <= CORE_TYPE[7];
                end
                if (sck_rise) begin
                    shift   <= {shift[5:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done <= 1'b1;
                        byte_val  <= {shift, mosi_s};
                        byte_idx  <= byte_cnt;
                        if (byte_cnt != 8'hFF)
                            byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                if (sck_fall)
                    miso_bit <= (byte_cnt == 8'd0) ? CORE_TYPE[~bit_cnt] : 1'b0;
            end
        end
    end

    // Command decode and register file
    logic [7:0] cmd;
    logic [7:0] but_sw;
    logic [7:0] joy_r [NUM_JOY][JOY_BYTES];
    logic [7:0] status_r [STATUS_BYTES];
    logic [2:0] mouse0, mouse1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmd    <= '0;
            but_sw <= '0;
            mouse0 <= '0;
            mouse1 <= '0;
            for (int unsigned i = 0; i < NUM_JOY; i++)
                for (int unsigned b = 0; b < JOY_BYTES; b++)
                    joy_r[i][b] <= '0;
            for (int unsigned b = 0; b < STATUS_BYTES; b++)
                status_r[b] <= '0;
        end else if (byte_done) begin
            if (byte_idx == 8'd0) begin
                cmd <= byte_val;
            end else begin
                if (cmd == 8'h01 && byte_idx == 8'd1)
                    but_sw <= byte_val;
                for (int unsigned i = 0; i < NUM_JOY; i++)
                    for (int unsigned b = 0; b < JOY_BYTES; b++)
                        if (cmd == 8'(8'h60 + i) && byte_idx == 8'(b + 1))
                            joy_r[i][b] <= byte_val;
                for (int unsigned b = 0; b < STATUS_BYTES; b++)
                    if (cmd == 8'h1E && byte_idx == 8'(b + 1))
                        status_r[b] <= byte_val;
                if (cmd[7:1] == 7'h38 && byte_idx == 8'd3) begin
                    if (cmd[0])
                        mouse1 <= byte_val[2:0];
                    else
                        mouse0 <= byte_val[2:0];
                end
            end
        end
    end

    assign BUTTONS        = but_sw[1:0];
    assign SWITCHES       = but_sw[3:2];
    assign CONF           = but_sw[7:4];
    assign MOUSE0_BUTTONS = mouse0;
    assign MOUSE1_BUTTONS = mouse1;

    always_comb begin
        JOY = '0;
        for (int unsigned i = 0; i < NUM_JOY; i++)
            for (int unsigned b = 0; b < JOY_BYTES; b++)
                JOY[(i*JOY_BYTES + b)*8 +: 8] = joy_r[i][b];
    end

    always_comb begin
        STATUS = '0;
        for (int unsigned b = 0; b < STATUS_BYTES; b++)
            STATUS[b*8 +: 8] = status_r[b];
    end

    // Event generation: at most one push per completed data byte
    logic push;
    evt_t push_entry;

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (byte_done && byte_idx != 8'd0) begin
            if (cmd[7:1] == 7'h38) begin
                push_entry = '{typ: 2'd0, wheel: 1'b0, idx: cmd[0], data: byte_val};
                case (byte_idx)
                    8'd1: push = 1'b1;
                    8'd2: begin
                        push           = 1'b1;
                        push_entry.typ = 2'd1;
                    end
                    8'd4: begin
                        push             = 1'b1;
                        push_entry.wheel = 1'b1;
                    end
                    default: push = 1'b0;
                endcase
            end else if (cmd == 8'h05) begin
                push       = 1'b1;
                push_entry = '{typ: 2'd2, wheel: 1'b0, idx: 1'b0, data: byte_val};
            end else if (cmd == 8'h06) begin
                push       = 1'b1;
                push_entry = '{typ: 2'd3, wheel: 1'b0, idx: 1'b0, data: byte_val};
            end
        end
    end

    // Event FIFO; a pop frees a slot in the same cycle so push+pop while full is accepted.
    evt_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, push_ok;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = (count != '0) & evt.EVT_READY;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            EVT_OVERFLOW <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push & full & ~pop)
                EVT_OVERFLOW <= 1'b1;
            else if (EVT_OVF_CLR)
                EVT_OVERFLOW <= 1'b0;
        end
    end

    assign evt.EVT_VALID = (count != '0);
    assign evt.EVT_TYPE  = mem[rd_ptr].typ;
    assign evt.EVT_WHEEL = mem[rd_ptr].wheel;
    assign evt.EVT_IDX   = mem[rd_ptr].idx;
    assign evt.EVT_DATA  = mem[rd_ptr].data;

`ifdef USER_IO_RTC_EN
    logic [7:0] rtc_r [8];
    logic       rtc_pend, rtc_stb;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rtc_pend <= 1'b0;
            rtc_stb  <= 1'b0;
            for (int unsigned b = 0; b < 8; b++)
                rtc_r[b] <= '0;
        end else begin
            rtc_pend <= byte_done && cmd == 8'h22 && byte_idx == 8'd8;
            rtc_stb  <= rtc_pend;
            if (byte_done && cmd == 8'h22)
                for (int unsigned b = 0; b < 8; b++)
                    if (byte_idx == 8'(b + 1))
                        rtc_r[b] <= byte_val;
        end
    end

    always_comb begin
        RTC = '0;
        for (int unsigned b = 0; b < 8; b++)
            RTC[b*8 +: 8] = rtc_r[b];
    end

    assign RTC_STROBE = rtc_stb;
`else
    assign RTC        = '0;
    assign RTC_STROBE = 1'b0;
`endif

endmodule

// File: tb/tb_user_io_fifo.sv
// Directed bench for user_io_fifo: register checks inline, event stream checked by a scoreboard monitor.
module tb_user_io_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    wire         miso;
    logic [7:0]  core_type = 8'hA5;
    logic [1:0]  buttons, switches;
    logic [3:0]  conf;
    logic [63:0] joy;
    logic [31:0] status;
    logic [2:0]  m0_btn, m1_btn;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic [63:0] rtc;
    logic        rtc_strobe;

    user_io_fifo_if evt ();

    user_io_fifo #(
        .NUM_JOY(4),
        .JOY_BYTES(2),
        .STATUS_BYTES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_sys(clk),
        .reset_n(reset_n),
        .SPI_CLK(sck),
        .SPI_SS_IO(ss),
        .SPI_MOSI(mosi),
        .SPI_MISO(miso),
        .CORE_TYPE(core_type),
        .BUTTONS(buttons),
        .SWITCHES(switches),
        .CONF(conf),
        .JOY(joy),
        .STATUS(status),
        .evt(evt),
        .MOUSE0_BUTTONS(m0_btn),
        .MOUSE1_BUTTONS(m1_btn),
        .EVT_OVERFLOW(ovf),
        .EVT_OVF_CLR(ovf_clr),
        .RTC(rtc),
        .RTC_STROBE(rtc_strobe)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         stb_cnt = 0;
    logic [11:0] sb [$];
    logic [7:0]  tx [$];
    logic [7:0]  miso_cap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head entry is checked against the oldest expectation.
    always @(negedge clk) begin
        logic [11:0] got, exp;
        if (reset_n && evt.EVT_VALID && evt.EVT_READY) begin
            vectors++;
            got = {evt.EVT_TYPE, evt.EVT_WHEEL, evt.EVT_IDX, evt.EVT_DATA};
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL evt_pop: got %h, required no event", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL evt_pop: got %h, required %h", got, exp);
                end
            end
        end
    end

    always @(negedge clk) if (rtc_strobe) stb_cnt++;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0, SCK = clk/8; MISO captured at the end of each low phase.
    task automatic send_byte(input logic [7:0] v, output logic [7:0] cap);
        for (int b = 7; b >= 0; b--) begin
            mosi = v[b];
            wait_clk(4);
            cap[b] = miso;
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
    endtask

    task automatic send();
        logic [7:0] c;
        ss = 1'b0;
        wait_clk(4);
        foreach (tx[i]) begin
            send_byte(tx[i], c);
            if (i == 0) miso_cap = c;
        end
        wait_clk(8);
        ss = 1'b1;
        wait_clk(8);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || evt.EVT_VALID) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0 || evt.EVT_VALID) begin
            miscompares++;
            $display("FAIL %s: %0d expected events left, valid %b, required 0 and 0", name, sb.size(), evt.EVT_VALID);
        end
    endtask

    initial begin
        logic [7:0] c;
        evt.EVT_READY = 1'b1;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(8);

        chk("reset_but_sw", {56'd0, conf, switches, buttons}, 64'd0);
        chk("reset_joy", joy, 64'd0);
        chk("reset_status", {32'd0, status}, 64'd0);
        chk("reset_evt", {58'd0, m1_btn, m0_btn}, 64'd0);
        chk("reset_flags", {62'd0, evt.EVT_VALID, ovf}, 64'd0);
        chk("reset_rtc", rtc, 64'd0);

        tx = {8'h01, 8'hA5};
        send();
        chk("miso_core_type", {56'd0, miso_cap}, 64'h00000000000000A5);
        chk("buttons", {62'd0, buttons}, 64'd1);
        chk("switches", {62'd0, switches}, 64'd1);
        chk("conf", {60'd0, conf}, 64'hA);

        tx = {8'h62, 8'h34, 8'h12, 8'hFF};
        send();
        chk("joy2", joy, 64'h0000_1234_0000_0000);
        tx = {8'h67, 8'h11};
        send();
        chk("joy_bad_index", joy, 64'h0000_1234_0000_0000);
        tx = {8'h63, 8'h5A};
        send();
        chk("joy3_low", joy, 64'h005A_1234_0000_0000);

        sb.push_back({2'd0, 1'b0, 1'b1, 8'h05});
        sb.push_back({2'd1, 1'b0, 1'b1, 8'hFB});
        sb.push_back({2'd0, 1'b1, 1'b1, 8'h01});
        tx = {8'h71, 8'h05, 8'hFB, 8'h03, 8'h01};
        send();
        drain("mouse_drain");
        chk("mouse1_buttons", {61'd0, m1_btn}, 64'd3);
        chk("mouse0_buttons", {61'd0, m0_btn}, 64'd0);

        sb.push_back({2'd3, 1'b0, 1'b0, 8'h3C});
        tx = {8'h06, 8'h3C};
        send();
        drain("osd_drain");

        evt.EVT_READY = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back({2'd2, 1'b0, 1'b0, 8'(8'h10 + i)});
        tx = {8'h05, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send();
        chk("full_valid", {63'd0, evt.EVT_VALID}, 64'd1);
        chk("overflow_set", {63'd0, ovf}, 64'd1);
        chk("head_stable", {52'd0, evt.EVT_TYPE, evt.EVT_WHEEL, evt.EVT_IDX, evt.EVT_DATA}, 64'h810);
        evt.EVT_READY = 1'b1;
        drain("key_drain");
        chk("overflow_sticky", {63'd0, ovf}, 64'd1);
        ovf_clr = 1'b1;
        wait_clk(1);
        ovf_clr = 1'b0;
        wait_clk(1);
        chk("overflow_clear", {63'd0, ovf}, 64'd0);

        ss = 1'b0;
        wait_clk(4);
        send_byte(8'h1E, c);
        send_byte(8'h11, c);
        wait_clk(8);
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        send_byte(8'h22, c);
        send_byte(8'h33, c);
        wait_clk(8);
        chk("status_after_reset", {32'd0, status}, 64'd0);
        chk("but_sw_after_reset", {56'd0, conf, switches, buttons}, 64'd0);
        ss = 1'b1;
        wait_clk(8);
        chk("status_still_zero", {32'd0, status}, 64'd0);
        tx = {8'h1E, 8'h78, 8'h56, 8'h34, 8'h12};
        send();
        chk("status_word", {32'd0, status}, 64'h12345678);

        stb_cnt = 0;
        tx = {8'h22, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send();
`ifdef USER_IO_RTC_EN
        chk("rtc_value", rtc, 64'h0807060504030201);
        chk("rtc_strobes", 64'(stb_cnt), 64'd1);
`else
        chk("rtc_value", rtc, 64'd0);
        chk("rtc_strobes", 64'(stb_cnt), 64'd0);
`endif
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
